// File: rtl/alu_pkg.sv
// Shared definitions for the iterative ALU: opcodes, FSM states, flag positions
// and the divide/sqrt core mode select.
package alu_pkg;

  localparam logic [4:0] OP_ADD  = 5'h00;
  localparam logic [4:0] OP_SUB  = 5'h01;
  localparam logic [4:0] OP_NEG  = 5'h02;
  localparam logic [4:0] OP_INC  = 5'h03;
  localparam logic [4:0] OP_DEC  = 5'h04;
  localparam logic [4:0] OP_MUL  = 5'h05;
  localparam logic [4:0] OP_DIV  = 5'h06;
  localparam logic [4:0] OP_REM  = 5'h07;
  localparam logic [4:0] OP_SQRT = 5'h08;
  localparam logic [4:0] OP_AND  = 5'h09;
  localparam logic [4:0] OP_OR   = 5'h0A;
  localparam logic [4:0] OP_NAND = 5'h0B;
  localparam logic [4:0] OP_NOR  = 5'h0C;
  localparam logic [4:0] OP_NOT  = 5'h0D;
  localparam logic [4:0] OP_XOR  = 5'h0E;
  localparam logic [4:0] OP_LSH  = 5'h0F;
  localparam logic [4:0] OP_RSH  = 5'h10;
  localparam logic [4:0] OP_ALSH = 5'h11;
  localparam logic [4:0] OP_ARSH = 5'h12;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DIV  = 2'd1,
    ST_SQRT = 2'd2,
    ST_FIX  = 2'd3
  } state_e;

  localparam int FLAG_CARRY = 0;
  localparam int FLAG_OVF   = 1;
  localparam int FLAG_ZERO  = 2;
  localparam int FLAG_GTZ   = 3;
  localparam int FLAG_LTZ   = 4;

  localparam logic MODE_DIV  = 1'b0;
  localparam logic MODE_SQRT = 1'b1;

endpackage

// File: rtl/alu_divsqrt.sv
// Iterative unsigned divide / floor-sqrt core. Both modes share one WIDTH+2-bit
// subtractor; one quotient or root bit is produced per clock.
module alu_divsqrt
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             mode,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] DIV_LAST  = CW'(WIDTH - 1);
  localparam logic [CW-1:0] SQRT_LAST = CW'(WIDTH / 2 - 1);

  logic             busy_r;
  logic             mode_r;
  logic [CW-1:0]    cnt_r;
  logic [WIDTH:0]   rem_r;
  logic [WIDTH-1:0] quo_r;
  logic [WIDTH-1:0] aux_r;

  logic [WIDTH+1:0] minuend_s;
  logic [WIDTH+1:0] subtrahend_s;
  logic [WIDTH+1:0] diff_s;
  logic [WIDTH:0]   rem_nxt_s;
  logic             fits_s;
  logic             last_s;
  logic             unused_s;

  // Trial subtraction: divisor in DIV mode, 4*root+1 in SQRT mode.
  always_comb begin
    minuend_s    = '0;
    subtrahend_s = '0;
    if (mode_r == MODE_SQRT) begin
      minuend_s    = {rem_r[WIDTH-1:0], aux_r[WIDTH-1:WIDTH-2]};
      subtrahend_s = {quo_r, 2'b01};
    end else begin
      minuend_s    = {rem_r, quo_r[WIDTH-1]};
      subtrahend_s = {2'b00, aux_r};
    end
    diff_s    = minuend_s - subtrahend_s;
    fits_s    = ~diff_s[WIDTH+1];
    rem_nxt_s = fits_s ? diff_s[WIDTH:0] : minuend_s[WIDTH:0];
  end

  assign unused_s  = minuend_s[WIDTH+1];
  assign last_s    = busy_r && (cnt_r == ((mode_r == MODE_SQRT) ? SQRT_LAST : DIV_LAST));
  // done is high during the cycle whose closing edge performs the final step
  assign done      = last_s;
  assign quotient  = quo_r;
  assign remainder = rem_r[WIDTH-1:0];

  // Iteration registers: load on start, then one shift/subtract step per clock.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_r <= 1'b0;
      mode_r <= MODE_DIV;
      cnt_r  <= '0;
      rem_r  <= '0;
      quo_r  <= '0;
      aux_r  <= '0;
    end else if (start) begin
      busy_r <= 1'b1;
      mode_r <= mode;
      cnt_r  <= '0;
      rem_r  <= '0;
      quo_r  <= (mode == MODE_SQRT) ? '0 : op_a;
      aux_r  <= (mode == MODE_SQRT) ? op_a : op_b;
    end else if (busy_r) begin
      busy_r <= ~last_s;
      cnt_r  <= cnt_r + CW'(1);
      rem_r  <= rem_nxt_s;
      quo_r  <= {quo_r[WIDTH-2:0], fits_s};
      if (mode_r == MODE_SQRT) begin
        aux_r <= {aux_r[WIDTH-3:0], 2'b00};
      end else begin
        aux_r <= aux_r;
      end
    end else begin
      busy_r <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_iter.sv
// Registered integer ALU. Single-cycle ops finish on the accepting edge;
// DIV/REM/SQRT run through alu_divsqrt and are sign-corrected in FIX.
module alu_iter
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  input  logic [4:0]       operation,
  input  logic             calc,
  output logic [WIDTH-1:0] result,
  output logic             calc_done,
  output logic [4:0]       flags
);

  localparam int SW = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] MAX_VAL = ~MIN_VAL;

  state_e           state_r, state_nxt_s;
  logic [WIDTH-1:0] result_r;
  logic             carry_r, ovf_r, calc_done_r;
  logic [4:0]       op_r;
  logic             a_neg_r, q_neg_r;

  logic [WIDTH:0]     sum_s, diff_s, inc_s, dec_s;
  logic [2*WIDTH-1:0] prod_s;
  logic [WIDTH-1:0]   abs_a_s, abs_b_s, res_s, fix_res_s;
  logic [SW-1:0]      sh_s;
  logic               carry_s, ovf_s, iter_s, accept_s, start_s, core_mode_s;
  logic               core_done_s;
  logic [WIDTH-1:0]   core_quo_s, core_rem_s;
  logic [4:0]         flags_s;

  assign accept_s    = calc && (state_r == ST_IDLE);
  assign start_s     = accept_s && iter_s;
  assign core_mode_s = (operation == OP_SQRT) ? MODE_SQRT : MODE_DIV;

  alu_divsqrt #(.WIDTH(WIDTH)) u_core (
    .clk       (clk),
    .rst       (rst),
    .start     (start_s),
    .mode      (core_mode_s),
    .op_a      ((operation == OP_SQRT) ? operand_a : abs_a_s),
    .op_b      (abs_b_s),
    .done      (core_done_s),
    .quotient  (core_quo_s),
    .remainder (core_rem_s)
  );

  // Single-cycle datapath plus divide special-case detection.
  always_comb begin
    sum_s   = {1'b0, operand_a} + {1'b0, operand_b};
    diff_s  = {1'b0, operand_a} - {1'b0, operand_b};
    inc_s   = {1'b0, operand_a} + (WIDTH+1)'(1);
    dec_s   = {1'b0, operand_a} - (WIDTH+1)'(1);
    prod_s  = {{WIDTH{operand_a[WIDTH-1]}}, operand_a} * {{WIDTH{operand_b[WIDTH-1]}}, operand_b};
    abs_a_s = operand_a[WIDTH-1] ? -operand_a : operand_a;
    abs_b_s = operand_b[WIDTH-1] ? -operand_b : operand_b;
    sh_s    = operand_b[SW-1:0];
    res_s   = '0;
    carry_s = 1'b0;
    ovf_s   = 1'b0;
    iter_s  = 1'b0;
    case (operation)
      OP_ADD: begin
        res_s   = sum_s[WIDTH-1:0];
        carry_s = sum_s[WIDTH];
        ovf_s   = (operand_a[WIDTH-1] == operand_b[WIDTH-1]) && (sum_s[WIDTH-1] != operand_a[WIDTH-1]);
      end
      OP_SUB: begin
        res_s   = diff_s[WIDTH-1:0];
        carry_s = diff_s[WIDTH];
        ovf_s   = (operand_a[WIDTH-1] != operand_b[WIDTH-1]) && (diff_s[WIDTH-1] != operand_a[WIDTH-1]);
      end
      OP_NEG: begin
        res_s = -operand_a;
        ovf_s = (operand_a == MIN_VAL);
      end
      OP_INC: begin
        res_s   = inc_s[WIDTH-1:0];
        carry_s = inc_s[WIDTH];
        ovf_s   = (operand_a == MAX_VAL);
      end
      OP_DEC: begin
        res_s   = dec_s[WIDTH-1:0];
        carry_s = dec_s[WIDTH];
        ovf_s   = (operand_a == MIN_VAL);
      end
      OP_MUL: begin
        res_s = prod_s[WIDTH-1:0];
        ovf_s = (prod_s[2*WIDTH-1:WIDTH-1] != {(WIDTH+1){prod_s[WIDTH-1]}});
      end
      OP_DIV, OP_REM: begin
        if (operand_b == '0) begin
          res_s = (operation == OP_DIV) ? '1 : operand_a;
          ovf_s = 1'b1;
        end else if ((operand_a == MIN_VAL) && (operand_b == '1)) begin
          res_s = (operation == OP_DIV) ? MIN_VAL : '0;
          ovf_s = 1'b1;
        end else begin
          iter_s = 1'b1;
        end
      end
      OP_SQRT:          iter_s = 1'b1;
      OP_AND:           res_s = operand_a & operand_b;
      OP_OR:            res_s = operand_a | operand_b;
      OP_NAND:          res_s = ~(operand_a & operand_b);
      OP_NOR:           res_s = ~(operand_a | operand_b);
      OP_NOT:           res_s = ~operand_a;
      OP_XOR:           res_s = operand_a ^ operand_b;
      OP_LSH, OP_ALSH:  res_s = operand_a << sh_s;
      OP_RSH:           res_s = operand_a >> sh_s;
      OP_ARSH:          res_s = $signed(operand_a) >>> sh_s;
      default:          res_s = '0;
    endcase
  end

  // Sign correction of the unsigned core results.
  always_comb begin
    case (op_r)
      OP_DIV:  fix_res_s = q_neg_r ? -core_quo_s : core_quo_s;
      OP_REM:  fix_res_s = a_neg_r ? -core_rem_s : core_rem_s;
      default: fix_res_s = core_quo_s;
    endcase
  end

  // Next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start_s) begin
          state_nxt_s = (operation == OP_SQRT) ? ST_SQRT : ST_DIV;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_DIV, ST_SQRT: begin
        if (core_done_s) begin
          state_nxt_s = ST_FIX;
        end else begin
          state_nxt_s = state_r;
        end
      end
      ST_FIX:  state_nxt_s = ST_IDLE;
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Result, status and latched-operation registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result_r    <= '0;
      carry_r     <= 1'b0;
      ovf_r       <= 1'b0;
      calc_done_r <= 1'b1;
      op_r        <= OP_ADD;
      a_neg_r     <= 1'b0;
      q_neg_r     <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (accept_s) begin
            op_r    <= operation;
            a_neg_r <= operand_a[WIDTH-1];
            q_neg_r <= operand_a[WIDTH-1] ^ operand_b[WIDTH-1];
            if (iter_s) begin
              calc_done_r <= 1'b0;
            end else begin
              result_r <= res_s;
              carry_r  <= carry_s;
              ovf_r    <= ovf_s;
            end
          end
        end
        ST_FIX: begin
          result_r    <= fix_res_s;
          carry_r     <= 1'b0;
          ovf_r       <= 1'b0;
          calc_done_r <= 1'b1;
        end
        default: calc_done_r <= calc_done_r;
      endcase
    end
  end

  // Flags decode from the registered result.
  always_comb begin
    flags_s             = '0;
    flags_s[FLAG_LTZ]   = result_r[WIDTH-1];
    flags_s[FLAG_ZERO]  = (result_r == '0);
    flags_s[FLAG_GTZ]   = !result_r[WIDTH-1] && (result_r != '0);
    flags_s[FLAG_OVF]   = ovf_r;
    flags_s[FLAG_CARRY] = carry_r;
  end

  assign result    = result_r;
  assign calc_done = calc_done_r;
  assign flags     = flags_s;

endmodule

// File: tb/tb_alu_iter.sv
// Self-checking bench for alu_iter at WIDTH=32: directed vector table,
// randomized ops against an arithmetic reference model, and multi-cycle corners.
module tb_alu_iter;
  import alu_pkg::*;

  localparam int W = 32;
  localparam longint MAXI = 64'sd2147483647;
  localparam longint MINI = -64'sd2147483648;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [W-1:0]  operand_a = '0;
  logic [W-1:0]  operand_b = '0;
  logic [4:0]    operation = 5'h00;
  logic          calc = 1'b0;
  logic [W-1:0]  result;
  logic          calc_done;
  logic [4:0]    flags;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [31:0] res;
    logic        ovf;
    logic        carry;
    int          lat;
  } exp_t;

  typedef struct {
    logic [4:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        ovf;
    logic        carry;
    int          lat;
  } vec_t;

  alu_iter #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .operand_a (operand_a),
    .operand_b (operand_b),
    .operation (operation),
    .calc      (calc),
    .result    (result),
    .calc_done (calc_done),
    .flags     (flags)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [4:0] exp_flags(input logic [31:0] r, input logic o, input logic c);
    return {r[31], (!r[31] && r != 32'h0), (r == 32'h0), o, c};
  endfunction

  function automatic logic out_of_range(input longint t);
    return (t > MAXI) || (t < MINI);
  endfunction

  // Reference model from the arithmetic definitions of each opcode.
  function automatic exp_t model(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    longint sa, sb, t, lo, hi, mid, ua;
    int sh;
    e.res = 32'h0; e.ovf = 1'b0; e.carry = 1'b0; e.lat = 0;
    sa = $signed(a);
    sb = $signed(b);
    sh = int'(b[4:0]);
    ua = longint'({32'h0, a});
    case (op)
      5'h00: begin t = sa + sb; e.res = 32'(t); e.ovf = out_of_range(t);
                   e.carry = (ua + longint'({32'h0, b})) > 64'sd4294967295; end
      5'h01: begin t = sa - sb; e.res = 32'(t); e.ovf = out_of_range(t); e.carry = (a < b); end
      5'h02: begin t = -sa; e.res = 32'(t); e.ovf = out_of_range(t); end
      5'h03: begin t = sa + 1; e.res = 32'(t); e.ovf = out_of_range(t); e.carry = (a == 32'hFFFFFFFF); end
      5'h04: begin t = sa - 1; e.res = 32'(t); e.ovf = out_of_range(t); e.carry = (a == 32'h0); end
      5'h05: begin t = sa * sb; e.res = 32'(t); e.ovf = out_of_range(t); end
      5'h06, 5'h07: begin
        if (b == 32'h0) begin
          e.res = (op == 5'h06) ? 32'hFFFFFFFF : a; e.ovf = 1'b1;
        end else if (sa == MINI && sb == -64'sd1) begin
          e.res = (op == 5'h06) ? a : 32'h0; e.ovf = 1'b1;
        end else begin
          e.res = (op == 5'h06) ? 32'(sa / sb) : 32'(sa % sb);
          e.lat = 33;
        end
      end
      5'h08: begin
        lo = 0; hi = 65536;
        while (hi - lo > 1) begin
          mid = (lo + hi) / 2;
          if (mid * mid <= ua) lo = mid; else hi = mid;
        end
        e.res = 32'(lo); e.lat = 17;
      end
      5'h09: e.res = a & b;
      5'h0A: e.res = a | b;
      5'h0B: e.res = ~(a & b);
      5'h0C: e.res = ~(a | b);
      5'h0D: e.res = ~a;
      5'h0E: e.res = a ^ b;
      5'h0F, 5'h11: e.res = a << sh;
      5'h10: e.res = a >> sh;
      5'h12: e.res = 32'(sa >>> sh);
      default: e.res = 32'h0;
    endcase
    return e;
  endfunction

  // Issue one operation and check latency, result and flags.
  task automatic run_op(input string name, input logic [4:0] op, input logic [31:0] a,
                        input logic [31:0] b, input exp_t e);
    int lat;
    operation = op; operand_a = a; operand_b = b; calc = 1'b1;
    @(posedge clk); #1;
    calc = 1'b0;
    lat = 0;
    while (calc_done !== 1'b1 && lat < 200) begin
      lat++;
      @(posedge clk); #1;
    end
    chk({name, " latency"}, 64'(lat), 64'(e.lat));
    chk({name, " result"}, 64'(result), 64'(e.res));
    chk({name, " flags"}, 64'(flags), 64'(exp_flags(e.res, e.ovf, e.carry)));
  endtask

  vec_t vecs[22];

  initial begin
    exp_t e;
    int lat;
    logic [4:0] rop;
    logic [31:0] ra, rb;

    vecs[0]  = '{OP_ADD,  32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b1, 1'b0, 0};
    vecs[1]  = '{OP_SUB,  32'h00000000, 32'h00000001, 32'hFFFFFFFF, 1'b0, 1'b1, 0};
    vecs[2]  = '{OP_MUL,  32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFF1, 1'b0, 1'b0, 0};
    vecs[3]  = '{OP_MUL,  32'h00010000, 32'h00010000, 32'h00000000, 1'b1, 1'b0, 0};
    vecs[4]  = '{OP_DIV,  32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD, 1'b0, 1'b0, 33};
    vecs[5]  = '{OP_REM,  32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 1'b0, 1'b0, 33};
    vecs[6]  = '{OP_SQRT, 32'd1000000,  32'h00000000, 32'd1000,     1'b0, 1'b0, 17};
    vecs[7]  = '{OP_SQRT, 32'hFFFFFFFF, 32'h00000000, 32'h0000FFFF, 1'b0, 1'b0, 17};
    vecs[8]  = '{OP_DIV,  32'h00000005, 32'h00000000, 32'hFFFFFFFF, 1'b1, 1'b0, 0};
    vecs[9]  = '{OP_DIV,  32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b1, 1'b0, 0};
    vecs[10] = '{OP_REM,  32'h00000007, 32'h00000000, 32'h00000007, 1'b1, 1'b0, 0};
    vecs[11] = '{OP_REM,  32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b0, 0};
    vecs[12] = '{OP_NEG,  32'h80000000, 32'h00000000, 32'h80000000, 1'b1, 1'b0, 0};
    vecs[13] = '{OP_INC,  32'hFFFFFFFF, 32'h00000000, 32'h00000000, 1'b0, 1'b1, 0};
    vecs[14] = '{OP_INC,  32'h7FFFFFFF, 32'h00000000, 32'h80000000, 1'b1, 1'b0, 0};
    vecs[15] = '{OP_DEC,  32'h00000000, 32'h00000000, 32'hFFFFFFFF, 1'b0, 1'b1, 0};
    vecs[16] = '{OP_DEC,  32'h80000000, 32'h00000000, 32'h7FFFFFFF, 1'b1, 1'b0, 0};
    vecs[17] = '{OP_ARSH, 32'h80000000, 32'h00000024, 32'hF8000000, 1'b0, 1'b0, 0};
    vecs[18] = '{OP_RSH,  32'h80000000, 32'h00000024, 32'h08000000, 1'b0, 1'b0, 0};
    vecs[19] = '{OP_NAND, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0FFF0FFF, 1'b0, 1'b0, 0};
    vecs[20] = '{5'h15,   32'h00000005, 32'h00000003, 32'h00000000, 1'b0, 1'b0, 0};
    vecs[21] = '{OP_REM,  32'h00000007, 32'hFFFFFFFE, 32'h00000001, 1'b0, 1'b0, 33};

    // Reset values, checked both during and after reset.
    repeat (2) @(posedge clk);
    #1;
    chk("reset result", 64'(result), 64'h0);
    chk("reset calc_done", 64'(calc_done), 64'h1);
    chk("reset flags", 64'(flags), 64'h04);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("post-reset flags", 64'(flags), 64'h04);

    for (int i = 0; i < 22; i++) begin
      e.res = vecs[i].res; e.ovf = vecs[i].ovf; e.carry = vecs[i].carry; e.lat = vecs[i].lat;
      run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, e);
    end

    for (int i = 0; i < 150; i++) begin
      rop = 5'($urandom_range(0, 31));
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 7))
        0: rb = 32'h0;
        1: begin ra = 32'h80000000; rb = 32'hFFFFFFFF; end
        2: rb = 32'($urandom_range(0, 40));
        3: ra = 32'($urandom_range(0, 1000));
        default: rb = rb;
      endcase
      run_op($sformatf("rand%0d op%0h", i, rop), rop, ra, rb, model(rop, ra, rb));
    end

    // calc pulsed with ADD while a DIV is busy must be ignored.
    run_op("pre-div add", OP_ADD, 32'd20, 32'd22, model(OP_ADD, 32'd20, 32'd22));
    operation = OP_DIV; operand_a = 32'd100; operand_b = 32'd7; calc = 1'b1;
    @(posedge clk); #1;
    calc = 1'b0;
    lat = 0;
    while (calc_done !== 1'b1 && lat < 200) begin
      lat++;
      if (lat == 6) begin
        operation = OP_ADD; operand_a = 32'd2; operand_b = 32'd3; calc = 1'b1;
      end else begin
        calc = 1'b0;
      end
      if (lat == 10) chk("busy result hold", 64'(result), 64'd42);
      @(posedge clk); #1;
    end
    calc = 1'b0;
    chk("div ignore latency", 64'(lat), 64'd33);
    chk("div ignore result", 64'(result), 64'd14);
    chk("div ignore flags", 64'(flags), 64'(exp_flags(32'd14, 1'b0, 1'b0)));

    // Asynchronous reset at iteration 10 aborts the divide.
    operation = OP_DIV; operand_a = 32'd1000; operand_b = 32'd3; calc = 1'b1;
    @(posedge clk); #1;
    calc = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    chk("busy before rst", 64'(calc_done), 64'h0);
    rst = 1'b1;
    #1;
    chk("async rst calc_done", 64'(calc_done), 64'h1);
    chk("async rst result", 64'(result), 64'h0);
    chk("async rst flags", 64'(flags), 64'h04);
    @(posedge clk); #1;
    rst = 1'b0;
    run_op("add after rst", OP_ADD, 32'd2, 32'd3, model(OP_ADD, 32'd2, 32'd3));
    run_op("div after rst", OP_DIV, 32'd1000, 32'd3, model(OP_DIV, 32'd1000, 32'd3));

    // Back-to-back single-cycle ops with calc held high.
    operation = OP_ADD; operand_a = 32'd1; operand_b = 32'd2; calc = 1'b1;
    @(posedge clk); #1;
    chk("b2b add", 64'(result), 64'd3);
    chk("b2b done", 64'(calc_done), 64'h1);
    operation = OP_SUB; operand_a = 32'd10; operand_b = 32'd4;
    @(posedge clk); #1;
    chk("b2b sub", 64'(result), 64'd6);
    operation = OP_LSH; operand_a = 32'd1; operand_b = 32'h3F;
    @(posedge clk); #1;
    chk("b2b lsh", 64'(result), 64'h80000000);
    chk("b2b lsh flags", 64'(flags), 64'h10);
    calc = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
